// File: rtl/timebase_pkg.sv
// rtl/timebase_pkg.sv - shared timebase parameters and stamp type
// Contents: default FINE_W/COARSE_W/NCH, drop counter width, stamp_t {coarse, fine}.
package timebase_pkg;

  localparam int FINE_W_DEF   = 5;
  localparam int COARSE_W_DEF = 48;
  localparam int NCH_DEF      = 4;
  localparam int DROP_W       = 8;

  // Stamp layout as seen by the packet builder: coarse in the upper bits.
  typedef struct packed {
    logic [COARSE_W_DEF-1:0] coarse;
    logic [FINE_W_DEF-1:0]   fine;
  } stamp_t;

endpackage

// File: rtl/timestamp_timebase_rr_arbiter.sv
// rtl/timestamp_timebase_rr_arbiter.sv - round-robin arbiter for pending stamps
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   req   [N]       request vector
//   en              grant enable; pointer advances only on an enabled grant
//   gnt   [N]       one-hot grant (zero when en=0 or no request)
//   gnt_idx [IW]    index of the granted request
//   gnt_any         a grant is issued this cycle
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          en,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          gnt_any
);

  // ptr holds the channel where the next search starts.
  logic [IW-1:0] ptr;

  always_comb begin
    int c;
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    c       = 0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (en && !gnt_any && req[c]) begin
        gnt_any = 1'b1;
        gnt_idx = IW'(c);
        gnt[c]  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (gnt_any) begin
      ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + IW'(1);
    end
  end

endmodule

// File: rtl/timestamp_timebase.sv
// rtl/timestamp_timebase.sv - coarse/fine timebase with multi-channel event stamping
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   sync, sync_coarse     load period counter (fine cleared)
//   ev [NCH]              event levels; rising edge captures a stamp
//   out_valid/out_ready   stamp stream handshake
//   out_ch, out_time      channel and {coarse, fine} of presented stamp
//   tick                  one-cycle pulse after coarse changes
//   coarse                live period counter
//   drop_cnt              saturating count of dropped events
module timestamp_timebase
  import timebase_pkg::*;
#(
  parameter int FINE_W   = FINE_W_DEF,
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int NCH      = NCH_DEF,
  parameter int CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       sync,
  input  logic [COARSE_W-1:0]        sync_coarse,
  input  logic [NCH-1:0]             ev,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CH_W-1:0]            out_ch,
  output logic [COARSE_W+FINE_W-1:0] out_time,
  output logic                       tick,
  output logic [COARSE_W-1:0]        coarse,
  output logic [DROP_W-1:0]          drop_cnt
);

  localparam int TW = COARSE_W + FINE_W;

  logic [FINE_W-1:0] fine;
  logic [NCH-1:0]    ev_d;
  logic [NCH-1:0]    pend;
  logic [TW-1:0]     slot [NCH];

  logic [NCH-1:0]    rise;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    drop_vec;
  logic [CH_W-1:0]   gnt_idx;
  logic              gnt_any;
  logic              load_out;
  logic              fine_max;
  logic [TW-1:0]     now;
  logic [DROP_W+4:0] drop_sum;
  logic [DROP_W-1:0] drop_nxt;

  assign fine_max = &fine;
  assign now      = {coarse, fine};
  assign rise     = ev & ~ev_d;
  assign load_out = ~out_valid | out_ready;
  // A rise on a still-pending slot is lost unless that slot drains this edge.
  assign drop_vec = rise & pend & ~gnt;

  rr_arbiter #(
    .N  (NCH),
    .IW (CH_W)
  ) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (pend),
    .en      (load_out),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  always_comb begin
    drop_sum = {5'b0, drop_cnt};
    for (int i = 0; i < NCH; i++) begin
      drop_sum = drop_sum + (DROP_W+5)'(drop_vec[i]);
    end
    drop_nxt = (drop_sum > (DROP_W+5)'({DROP_W{1'b1}})) ? {DROP_W{1'b1}} : drop_sum[DROP_W-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fine      <= '0;
      coarse    <= '0;
      tick      <= 1'b0;
      ev_d      <= '0;
      pend      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_time  <= '0;
      drop_cnt  <= '0;
      for (int i = 0; i < NCH; i++) slot[i] <= '0;
    end else begin
      // Sync loads always count as a coarse change, even to the same value.
      tick <= sync | fine_max;
      if (sync) begin
        fine   <= '0;
        coarse <= sync_coarse;
      end else begin
        fine <= fine + FINE_W'(1);
        if (fine_max) coarse <= coarse + COARSE_W'(1);
      end

      ev_d <= ev;
      pend <= (pend & ~gnt) | rise;
      for (int i = 0; i < NCH; i++) begin
        if (rise[i] && !drop_vec[i]) slot[i] <= now;
      end
      drop_cnt <= drop_nxt;

      if (load_out) begin
        out_valid <= gnt_any;
        if (gnt_any) begin
          out_ch   <= gnt_idx;
          out_time <= slot[gnt_idx];
        end
      end
    end
  end

endmodule
